// File: rtl/exec_unit.sv
// Execute/write-back stage: captures register-file operands on start and runs single-cycle ALU ops
// or iterative shift-add multiply / restoring divide, then drives the register-file write port.
module exec_unit #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] wd3,
  output logic [AW-1:0]    wa3,
  output logic             we3
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_DIVU = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_p0;
  logic [AW-1:0]    dest_p0;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc, acc_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [WIDTH-1:0] opnd, opnd_nxt;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] alu_res, iter_res;
  logic             is_iter;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [AW-1:0]    wa_q;

  function automatic logic [WIDTH-1:0] alu(input logic [2:0] f,
                                           input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] sx;
    logic signed [WIDTH-1:0] sy;
    sx = x;
    sy = y;
    case (f)
      OP_ADD:  alu = x + y;
      OP_SUB:  alu = x - y;
      OP_AND:  alu = x & y;
      OP_OR:   alu = x | y;
      OP_SLT:  alu = {{(WIDTH-1){1'b0}}, (sx < sy)};
      default: alu = '0;
    endcase
  endfunction

  assign alu_res = alu(op, a, b);
  assign is_iter = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);

  // One iteration: MUL uses acc as partial product, sh as multiplier, opnd as shifting multiplicand.
  // Divide uses acc as partial remainder, sh as dividend shifting into quotient, opnd as divisor.
  always_comb begin
    acc_nxt  = acc;
    sh_nxt   = sh;
    opnd_nxt = opnd;
    trial    = '0;
    if (op_p0 == OP_MUL) begin
      acc_nxt  = {1'b0, acc[WIDTH-1:0] + (sh[0] ? opnd : '0)};
      sh_nxt   = sh >> 1;
      opnd_nxt = opnd << 1;
    end else begin
      trial = {acc[WIDTH-1:0], sh[WIDTH-1]} - {1'b0, opnd};
      if (!trial[WIDTH]) begin
        acc_nxt = trial;
        sh_nxt  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[WIDTH-1:0], sh[WIDTH-1]};
        sh_nxt  = {sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  // A zero divisor never fails the trial subtraction, giving all-ones quotient and remainder = a.
  assign iter_res = (op_p0 == OP_DIVU) ? sh_nxt : acc_nxt[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = is_iter ? CALC : WB;
      CALC: if (cnt == CNT_LAST) state_nxt = WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_p0    <= '0;
      dest_p0  <= '0;
      cnt      <= '0;
      acc      <= '0;
      sh       <= '0;
      opnd     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      wa_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_p0   <= op;
            dest_p0 <= dest;
            if (is_iter) begin
              cnt  <= CNT_INIT;
              acc  <= '0;
              sh   <= (op == OP_MUL) ? b : a;
              opnd <= (op == OP_MUL) ? a : b;
            end else begin
              result_q <= alu_res;
              zero_q   <= (alu_res == '0);
              wa_q     <= dest;
            end
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          sh   <= sh_nxt;
          opnd <= opnd_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            result_q <= iter_res;
            zero_q   <= (iter_res == '0);
            wa_q     <= dest_p0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == WB);
  assign we3    = (state == WB);
  assign result = result_q;
  assign wd3    = result_q;
  assign zero   = zero_q;
  assign wa3    = wa_q;

endmodule
